// File: rtl/cfi_violation_handler_if.sv
// ---------------------------------------------------------------------------
// cfi_violation_handler_if : exception types plus CSR/checker/controller bundle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ariane_pkg;
  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception_t;

  localparam logic [63:0] BREAKPOINT = 64'd3;
endpackage

interface cfi_violation_handler_if #(
  parameter int CNT_W = 8
);
  logic                   enable_i;
  logic                   clear_i;
  ariane_pkg::exception_t chk_ex_i;
  logic [63:0]            viol_pc_i;
  logic                   ex_taken_i;
  ariane_pkg::exception_t ex_o;
  logic                   pending_o;
  logic [CNT_W-1:0]       violation_cnt_o;
  logic                   dropped_o;
  logic                   lockout_o;

  modport slave (
    input  enable_i, clear_i, chk_ex_i, viol_pc_i, ex_taken_i,
    output ex_o, pending_o, violation_cnt_o, dropped_o, lockout_o
  );

  modport master (
    output enable_i, clear_i, chk_ex_i, viol_pc_i, ex_taken_i,
    input  ex_o, pending_o, violation_cnt_o, dropped_o, lockout_o
  );
endinterface

`default_nettype wire

// File: rtl/cfi_violation_handler.sv
// ---------------------------------------------------------------------------
// cfi_violation_handler : turns CFI checker events into held exceptions,
// counts them, suppresses re-triggers during flush and raises sticky lockout.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cfi_violation_handler #(
  parameter int CNT_W          = 8,
  parameter int LOCK_THRESHOLD = 4,
  parameter int HOLDOFF_CYCLES = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  cfi_violation_handler_if.slave  bus
);

  localparam int               HOLD_W    = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    HOLDOFF = 2'd2,
    LOCKED  = 2'd3
  } state_t;

  state_t                 state;
  ariane_pkg::exception_t ex_q;
  logic                   pending_q;
  logic                   dropped_q;
  logic                   lockout_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [HOLD_W-1:0]      hold_q;

  logic                   evt;
  logic [CNT_W-1:0]       cnt_base;
  logic [CNT_W-1:0]       cnt_inc;
  logic                   lock_base;
  logic                   lock_hit;
  logic                   unused_tval;

  assign evt         = bus.chk_ex_i.valid & bus.enable_i;
  assign unused_tval = ^bus.chk_ex_i.tval;

  // Clear is folded in before any increment so clear+event in IDLE yields a count of 1.
  always_comb begin
    cnt_base  = bus.clear_i ? '0 : cnt_q;
    cnt_inc   = (cnt_base == CNT_MAX) ? cnt_base : cnt_base + CNT_W'(1);
    lock_base = bus.clear_i ? 1'b0 : lockout_q;
    lock_hit  = (LOCK_THRESHOLD != 0) && (32'(cnt_inc) >= LOCK_THRESHOLD);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      ex_q      <= '0;
      pending_q <= 1'b0;
      dropped_q <= 1'b0;
      lockout_q <= 1'b0;
      cnt_q     <= '0;
      hold_q    <= '0;
    end else begin
      cnt_q     <= cnt_base;
      lockout_q <= lock_base;
      dropped_q <= bus.clear_i ? 1'b0 : dropped_q;
      case (state)
        IDLE: begin
          if (evt) begin
            ex_q.valid <= 1'b1;
            ex_q.cause <= bus.chk_ex_i.cause;
            ex_q.tval  <= bus.viol_pc_i;
            cnt_q      <= cnt_inc;
            lockout_q  <= lock_base | lock_hit;
            pending_q  <= 1'b1;
            state      <= PENDING;
          end
        end
        PENDING: begin
          if (evt) dropped_q <= 1'b1;
          if (bus.ex_taken_i) begin
            ex_q      <= '0;
            pending_q <= 1'b0;
            if (HOLDOFF_CYCLES == 0) begin
              state <= lock_base ? LOCKED : IDLE;
            end else begin
              hold_q <= HOLD_LOAD;
              state  <= HOLDOFF;
            end
          end
        end
        HOLDOFF: begin
          if (evt) dropped_q <= 1'b1;
          if (hold_q <= HOLD_W'(1)) begin
            hold_q <= '0;
            state  <= lock_base ? LOCKED : IDLE;
          end else begin
            hold_q <= hold_q - HOLD_W'(1);
          end
        end
        LOCKED: begin
          if (bus.clear_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ex_o            = ex_q;
  assign bus.pending_o       = pending_q;
  assign bus.violation_cnt_o = cnt_q;
  assign bus.dropped_o       = dropped_q;
  assign bus.lockout_o       = lockout_q;

endmodule

`default_nettype wire

// File: tb/tb_cfi_violation_handler.sv
// ---------------------------------------------------------------------------
// tb_cfi_violation_handler : scoreboard bench for cfi_violation_handler
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_cfi_violation_handler;
  import ariane_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cfi_violation_handler_if #(.CNT_W(8)) ia ();
  cfi_violation_handler_if #(.CNT_W(2)) ib ();

  cfi_violation_handler #(.CNT_W(8), .LOCK_THRESHOLD(4), .HOLDOFF_CYCLES(8)) dut_a (
    .clk_i(clk), .rst_i(rst), .bus(ia)
  );
  cfi_violation_handler #(.CNT_W(2), .LOCK_THRESHOLD(0), .HOLDOFF_CYCLES(8)) dut_b (
    .clk_i(clk), .rst_i(rst), .bus(ib)
  );

  typedef struct {
    logic [63:0] cause;
    logic [63:0] tval;
  } exp_t;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];
  exp_t mon_e;
  logic prev_valid = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [63:0] cause, input logic [63:0] pc, input bit capture);
    exp_t e;
    ia.chk_ex_i.valid = 1'b1;
    ia.chk_ex_i.cause = cause;
    ia.viol_pc_i      = pc;
    if (capture) begin
      e.cause = cause;
      e.tval  = pc;
      sb_q.push_back(e);
    end
    tick();
    ia.chk_ex_i.valid = 1'b0;
  endtask

  task automatic ack_a();
    ia.ex_taken_i = 1'b1;
    tick();
    ia.ex_taken_i = 1'b0;
    repeat (8) tick();
  endtask

  task automatic clear_a();
    ia.clear_i = 1'b1;
    tick();
    ia.clear_i = 1'b0;
  endtask

  // Each new exception request is matched against the oldest captured event.
  always @(negedge clk) begin
    if (ia.ex_o.valid && !prev_valid) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_ex", 64'd1, 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("sb_cause", ia.ex_o.cause, mon_e.cause);
        check("sb_tval", ia.ex_o.tval, mon_e.tval);
      end
    end
    prev_valid <= ia.ex_o.valid;
  end

  initial begin
    rst = 1'b1;
    ia.enable_i = 1'b1; ia.clear_i = 1'b0; ia.chk_ex_i = '0; ia.viol_pc_i = '0; ia.ex_taken_i = 1'b0;
    ib.enable_i = 1'b1; ib.clear_i = 1'b0; ib.chk_ex_i = '0; ib.viol_pc_i = '0; ib.ex_taken_i = 1'b0;
    tick();
    tick();
    check("rst_valid", ia.ex_o.valid, 0);
    check("rst_cause", ia.ex_o.cause, 0);
    check("rst_tval", ia.ex_o.tval, 0);
    check("rst_cnt", ia.violation_cnt_o, 0);
    check("rst_dropped", ia.dropped_o, 0);
    check("rst_lockout", ia.lockout_o, 0);
    check("rst_pending", ia.pending_o, 0);
    rst = 1'b0;
    tick();

    // Capture and hold, including enable falling while pending.
    send_a(BREAKPOINT, 64'h8000_1000, 1'b1);
    check("cap_pending", ia.pending_o, 1);
    check("cap_cnt", ia.violation_cnt_o, 1);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) ia.enable_i = 1'b0;
      tick();
      check("hold_valid", ia.ex_o.valid, 1);
      check("hold_tval", ia.ex_o.tval, 64'h8000_1000);
    end
    ia.enable_i = 1'b1;

    // Acknowledge, then probe the holdoff window edges.
    ia.ex_taken_i = 1'b1;
    tick();
    ia.ex_taken_i = 1'b0;
    check("ack_valid", ia.ex_o.valid, 0);
    check("ack_cause", ia.ex_o.cause, 0);
    check("ack_pending", ia.pending_o, 0);
    tick();
    tick();
    send_a(BREAKPOINT, 64'h8000_2000, 1'b0);
    check("hold_dropped", ia.dropped_o, 1);
    check("hold_cnt", ia.violation_cnt_o, 1);
    clear_a();
    check("clr_dropped", ia.dropped_o, 0);
    check("clr_cnt", ia.violation_cnt_o, 0);
    repeat (3) tick();
    send_a(BREAKPOINT, 64'h8000_3000, 1'b0);
    check("last_hold_dropped", ia.dropped_o, 1);
    check("last_hold_pending", ia.pending_o, 0);
    send_a(BREAKPOINT, 64'h8000_4000, 1'b1);
    check("idle_again_pending", ia.pending_o, 1);
    check("idle_again_cnt", ia.violation_cnt_o, 1);
    ack_a();
    clear_a();

    // Disabled: events are ignored entirely.
    ia.enable_i = 1'b0;
    for (int i = 0; i < 3; i++) send_a(BREAKPOINT, 64'h9000_0000 + 64'(i), 1'b0);
    check("dis_valid", ia.ex_o.valid, 0);
    check("dis_pending", ia.pending_o, 0);
    check("dis_cnt", ia.violation_cnt_o, 0);
    check("dis_dropped", ia.dropped_o, 0);
    ia.enable_i = 1'b1;

    // Lockout after four acknowledged violations.
    for (int i = 1; i <= 4; i++) begin
      send_a(BREAKPOINT, 64'hA000_0000 + 64'(i * 4), 1'b1);
      check("lk_cnt", ia.violation_cnt_o, 64'(i));
      check("lk_lockout", ia.lockout_o, (i == 4) ? 64'd1 : 64'd0);
      check("lk_pending", ia.pending_o, 1);
      ack_a();
    end
    check("locked_lockout", ia.lockout_o, 1);
    send_a(BREAKPOINT, 64'hA000_0100, 1'b0);
    check("locked_valid", ia.ex_o.valid, 0);
    check("locked_pending", ia.pending_o, 0);
    check("locked_dropped", ia.dropped_o, 0);
    check("locked_cnt", ia.violation_cnt_o, 4);
    clear_a();
    check("unlock_lockout", ia.lockout_o, 0);
    check("unlock_cnt", ia.violation_cnt_o, 0);
    send_a(BREAKPOINT, 64'hA000_0200, 1'b1);
    check("unlock_pending", ia.pending_o, 1);
    check("unlock_cnt1", ia.violation_cnt_o, 1);
    ack_a();

    // Narrow counter saturates; lockout disabled.
    for (int i = 1; i <= 5; i++) begin
      ib.chk_ex_i.valid = 1'b1;
      ib.chk_ex_i.cause = BREAKPOINT;
      ib.viol_pc_i      = 64'hB000_0000 + 64'(i);
      tick();
      ib.chk_ex_i.valid = 1'b0;
      check("sat_tval", ib.ex_o.tval, 64'hB000_0000 + 64'(i));
      check("sat_cnt", ib.violation_cnt_o, (i > 3) ? 64'd3 : 64'(i));
      check("sat_lockout", ib.lockout_o, 0);
      ib.ex_taken_i = 1'b1;
      tick();
      ib.ex_taken_i = 1'b0;
      repeat (8) tick();
    end

    // Asynchronous reset in the middle of a pending exception.
    send_a(BREAKPOINT, 64'hC000_0000, 1'b0);
    check("pre_rst_pending", ia.pending_o, 1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", ia.ex_o.valid, 0);
    check("arst_tval", ia.ex_o.tval, 0);
    check("arst_pending", ia.pending_o, 0);
    check("arst_cnt", ia.violation_cnt_o, 0);
    check("arst_dropped", ia.dropped_o, 0);
    tick();
    rst = 1'b0;
    tick();

    check("sb_empty", 64'(sb_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cfi_violation_handler.md
Name: cfi_violation_handler

Overview:
- Sits directly downstream of the commit-stage RET/NOP checker.
- Consumes the checker's registered breakpoint exception and turns it into a held exception request for the controller, with tval set to the offending PC.
- Counts violations and suppresses re-triggers while the pipeline flushes.
- Raises a sticky lockout/halt request once a threshold is reached.

Parameters:
- CNT_W, 8, width of the violation counter.
- LOCK_THRESHOLD, 4, counter value at which lockout asserts; 0 disables lockout.
- HOLDOFF_CYCLES, 8, cycles after a taken trap during which checker events are ignored.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-high.
- enable_i  in  1  CSR enable; when low, checker events are ignored in IDLE.
- clear_i  in  1  CSR pulse; clears counter, dropped_o and lockout.
- chk_ex_i  in  ariane_pkg::exception_t  checker output; only .valid and .cause are used.
- viol_pc_i  in  64  PC of the violating commit, aligned with chk_ex_i.
- ex_taken_i  in  1  controller has taken the trap this cycle.
- ex_o  out  ariane_pkg::exception_t  exception request to the commit/controller path.
- pending_o  out  1  exception held, awaiting ex_taken_i.
- violation_cnt_o  out  CNT_W  saturating violation count.
- dropped_o  out  1  sticky: a violation arrived while not in IDLE.
- lockout_o  out  1  sticky lockout / halt request.

Behaviour:
- Reset (asynchronous, rst_i=1):
  - state=IDLE.
  - ex_o.valid=0, ex_o.cause=0, ex_o.tval=0.
  - counter=0, dropped_o=0, lockout_o=0, holdoff counter=0.
- All outputs are registered.
- Event definition: event = chk_ex_i.valid & enable_i.
- FSM states: IDLE, PENDING, HOLDOFF, LOCKED.
- IDLE, event occurs, next cycle:
  - ex_o.valid=1, ex_o.cause=chk_ex_i.cause, ex_o.tval=viol_pc_i.
  - counter += 1, saturating at 2^CNT_W-1.
  - state=PENDING.
  - One-cycle latency from event to ex_o.valid.
- PENDING:
  - ex_o is held stable until ex_taken_i.
  - flush_i is not an input; a pending exception is never cancelled except by reset.
  - ex_taken_i=1 → ex_o cleared to all-zero; holdoff counter loaded with HOLDOFF_CYCLES; state=HOLDOFF. If HOLDOFF_CYCLES=0, go straight to IDLE.
  - An event while in PENDING is not captured, not counted, and sets dropped_o.
- HOLDOFF:
  - Holdoff counter decrements each cycle.
  - Events set dropped_o only.
  - When the counter reaches 1 → IDLE, or LOCKED if lockout_o=1.
- Lockout:
  - lockout_o sets in the same cycle the counter update makes counter >= LOCK_THRESHOLD (only when LOCK_THRESHOLD != 0).
  - The exception that triggered lockout is still delivered through PENDING and HOLDOFF before the FSM enters LOCKED.
- LOCKED:
  - ex_o.valid=0 and lockout_o=1.
  - Events are ignored and do not set dropped_o.
  - Exit only via clear_i or reset.
- clear_i (synchronous, highest priority after reset):
  - counter=0, dropped_o=0, lockout_o=0.
  - If in LOCKED → IDLE.
  - In other states, the state is unchanged and a pending ex_o is kept.
- Simultaneous event and clear_i in IDLE: clear applies first, then the event is captured (counter=1).
- enable_i falling while in PENDING does not withdraw ex_o.
- pending_o = (state==PENDING).
- violation_cnt_o reflects the registered counter.

Test Plan:
- Reset, enable_i=1, single chk_ex_i.valid pulse (cause=BREAKPOINT, viol_pc_i=0x8000_1000) → next cycle ex_o.valid=1, cause=BREAKPOINT, tval=0x8000_1000, pending_o=1, violation_cnt_o=1. Hold ex_taken_i=0 for 5 cycles → ex_o unchanged.
- From PENDING assert ex_taken_i; pulse chk_ex_i.valid 3 cycles later → ex_o clears next cycle; the pulse during holdoff sets dropped_o=1, counter stays 1; state returns to IDLE after 8 cycles.
- enable_i=0 with chk_ex_i.valid pulses → no ex_o, counter=0, dropped_o=0.
- 4 violations, each acknowledged (LOCK_THRESHOLD=4) → lockout_o=1 on the 4th capture; 4th exception still delivered; after holdoff state=LOCKED; a further pulse → no ex_o. Pulse clear_i → lockout_o=0, counter=0, IDLE.
- CNT_W=2, LOCK_THRESHOLD=0, 5 acknowledged violations → violation_cnt_o saturates at 3, lockout_o never asserts.
- Assert rst_i asynchronously mid-PENDING (between clock edges) → ex_o.valid=0 and all outputs zero immediately, without waiting for a clock edge.
